// File: rtl/order_tx.sv
// +--------------------------------------------------------------------------+
// | order_tx : turns buy/sell decisions into single order packets on a      |
// |            valid/ready stream with net-position limit and cooldown.      |
// | Optional handshake timeout: define ORDER_TX_TIMEOUT_EN.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module order_tx #(
   parameter logic        [7:0]  QTY      = 8'd1,
   parameter logic signed [7:0]  MAX_POS  = 8'sd16,
   parameter logic        [15:0] COOLDOWN = 16'd4,
   parameter logic        [15:0] TIMEOUT  = 16'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        buy_signal,
   input  logic        sell_signal,
   input  logic [7:0]  price,
   input  logic        order_ready,
   output logic        order_valid,
   output logic        order_side,
   output logic [7:0]  order_price,
   output logic [7:0]  order_qty,
   output logic [15:0] order_id,
   output logic [7:0]  position,
   output logic [7:0]  reject_count
`ifdef ORDER_TX_TIMEOUT_EN
   ,
   output logic        order_timeout
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_COOL = 2'd2
   } state_t;

   state_t             state_q;
   logic               order_valid_q;
   logic               order_side_q;
   logic [7:0]         order_price_q;
   logic [7:0]         order_qty_q;
   logic [15:0]        order_id_q;
   logic [7:0]         position_q;
   logic [7:0]         reject_count_q;
   logic [15:0]        cool_q;

   logic signed [8:0]  pos_ext_d;
   logic signed [8:0]  buy_sum_d;
   logic signed [8:0]  sell_diff_d;
   logic               buy_ok_d;
   logic               sell_ok_d;
   logic [7:0]         reject_inc_d;

   // A zero quantity or zero timeout is a configuration error.
   if (QTY == 8'd0 || TIMEOUT == 16'd0) begin : g_param_check
      $error("order_tx: QTY and TIMEOUT must be nonzero");
   end

   // Limit checks run one bit wider than position so they cannot wrap.
   always_comb begin
      pos_ext_d    = {position_q[7], position_q};
      buy_sum_d    = pos_ext_d + $signed({1'b0, QTY});
      sell_diff_d  = pos_ext_d - $signed({1'b0, QTY});
      buy_ok_d     = buy_sum_d <= $signed({MAX_POS[7], MAX_POS});
      sell_ok_d    = sell_diff_d >= -$signed({MAX_POS[7], MAX_POS});
      reject_inc_d = (reject_count_q == 8'hFF) ? reject_count_q : reject_count_q + 8'd1;
   end

`ifdef ORDER_TX_TIMEOUT_EN
   logic [15:0] to_q;
   logic        order_timeout_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         order_valid_q  <= 1'b0;
         order_side_q   <= 1'b0;
         order_price_q  <= 8'd0;
         order_qty_q    <= 8'd0;
         order_id_q     <= 16'd0;
         position_q     <= 8'd0;
         reject_count_q <= 8'd0;
         cool_q         <= 16'd0;
`ifdef ORDER_TX_TIMEOUT_EN
         to_q            <= 16'd0;
         order_timeout_q <= 1'b0;
`endif
      end else begin
`ifdef ORDER_TX_TIMEOUT_EN
         order_timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (buy_signal && sell_signal) begin
                  reject_count_q <= reject_inc_d;
               end else if (buy_signal || sell_signal) begin
                  if ((buy_signal && buy_ok_d) || (sell_signal && sell_ok_d)) begin
                     order_side_q  <= buy_signal;
                     order_price_q <= price;
                     order_qty_q   <= QTY;
                     order_valid_q <= 1'b1;
                     state_q       <= S_SEND;
`ifdef ORDER_TX_TIMEOUT_EN
                     to_q          <= 16'd0;
`endif
                  end else begin
                     reject_count_q <= reject_inc_d;
                  end
               end
            end
            S_SEND: begin
               if (order_ready) begin
                  order_valid_q <= 1'b0;
                  order_qty_q   <= 8'd0;
                  order_id_q    <= order_id_q + 16'd1;
                  position_q    <= order_side_q ? position_q + QTY : position_q - QTY;
                  if (COOLDOWN == 16'd0) begin
                     state_q <= S_IDLE;
                  end else begin
                     cool_q  <= COOLDOWN - 16'd1;
                     state_q <= S_COOL;
                  end
`ifdef ORDER_TX_TIMEOUT_EN
               end else if (to_q == TIMEOUT - 16'd1) begin
                  // Withdraw the stalled order without touching position or ID.
                  order_valid_q   <= 1'b0;
                  order_qty_q     <= 8'd0;
                  order_timeout_q <= 1'b1;
                  reject_count_q  <= reject_inc_d;
                  state_q         <= S_IDLE;
               end else begin
                  to_q <= to_q + 16'd1;
`endif
               end
            end
            S_COOL: begin
               if (cool_q == 16'd0) begin
                  state_q <= S_IDLE;
               end else begin
                  cool_q <= cool_q - 16'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign order_valid  = order_valid_q;
   assign order_side   = order_side_q;
   assign order_price  = order_price_q;
   assign order_qty    = order_qty_q;
   assign order_id     = order_id_q;
   assign position     = position_q;
   assign reject_count = reject_count_q;
`ifdef ORDER_TX_TIMEOUT_EN
   assign order_timeout = order_timeout_q;
`endif

endmodule

`default_nettype wire
